// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - 8-entry out-of-order issue buffer feeding a single ALU
module alu_issue_sched #(
    parameter int CNTRL_SIZE = 7,
    parameter int NCOMMIT    = 32,
    parameter int LNCOMMIT   = 5,
    parameter int VA_SZ      = 48,
    parameter int NENT       = 8,
    parameter int LNENT      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNTRL_SIZE-1:0] in_control,
    input  logic [LNCOMMIT-1:0]   in_rd,
    input  logic                  in_makes_rd,
    input  logic                  in_needs_rs2,
    input  logic [LNCOMMIT-1:0]   in_rs1,
    input  logic [LNCOMMIT-1:0]   in_rs2,
    input  logic                  in_rs1_ready,
    input  logic                  in_rs2_ready,
    input  logic [31:0]           in_immed,
    input  logic [VA_SZ-1:1]      in_pc,
    input  logic                  wake_valid,
    input  logic [LNCOMMIT-1:0]   wake_rd,
    input  logic [NCOMMIT-1:0]    commit_kill,
    output logic                  alu_enable,
    output logic [CNTRL_SIZE-1:0] alu_control,
    output logic [LNCOMMIT-1:0]   alu_rd,
    output logic                  alu_makes_rd,
    output logic                  alu_needs_rs2,
    output logic [31:0]           alu_immed,
    output logic [VA_SZ-1:1]      alu_pc,
    output logic [LNCOMMIT-1:0]   rf_rs1,
    output logic [LNCOMMIT-1:0]   rf_rs2,
    output logic [LNENT:0]        count
);

    logic [NENT-1:0]       valid_q, rs1_rdy_q, rs2_rdy_q;
    logic [NENT-1:0]       valid_n, rs1_rdy_n, rs2_rdy_n;
    logic [LNCOMMIT-1:0]   rd_q   [NENT];
    logic [LNCOMMIT-1:0]   rs1_q  [NENT];
    logic [LNCOMMIT-1:0]   rs2_q  [NENT];
    logic [CNTRL_SIZE-1:0] ctl_q  [NENT];
    logic                  mrd_q  [NENT];
    logic                  nrs2_q [NENT];
    logic [31:0]           imm_q  [NENT];
    logic [VA_SZ-1:1]      pc_q   [NENT];
    // age_q[i][j] set means entry i was inserted before entry j
    logic [NENT-1:0]       age_q  [NENT];

    logic [NENT-1:0]  eligible, sel_oh;
    logic [LNENT-1:0] sel_idx, wr_idx;
    logic             any_sel, do_write, int_wake;
    logic [LNENT:0]   count_n;

    function automatic logic woken(input logic [LNCOMMIT-1:0] tag,
                                   input logic ev, input logic [LNCOMMIT-1:0] et,
                                   input logic iv, input logic [LNCOMMIT-1:0] it);
        return (ev && et == tag) || (iv && it == tag);
    endfunction

    always_comb begin
        in_ready = (count != (LNENT+1)'(NENT));
        int_wake = alu_enable & alu_makes_rd;
        do_write = in_valid & in_ready & ~commit_kill[in_rd];

        for (int i = 0; i < NENT; i++)
            eligible[i] = valid_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i] & ~commit_kill[rd_q[i]];

        // An entry wins only if it is older than every other eligible entry
        sel_oh = '0;
        for (int i = 0; i < NENT; i++) begin
            sel_oh[i] = eligible[i];
            for (int j = 0; j < NENT; j++)
                if (j != i && eligible[j] && !age_q[i][j])
                    sel_oh[i] = 1'b0;
        end
        any_sel = |sel_oh;
        sel_idx = '0;
        for (int i = 0; i < NENT; i++)
            if (sel_oh[i]) sel_idx = LNENT'(i);

        wr_idx = '0;
        for (int i = NENT-1; i >= 0; i--)
            if (!valid_q[i]) wr_idx = LNENT'(i);

        for (int i = 0; i < NENT; i++) begin
            valid_n[i]   = valid_q[i] & ~sel_oh[i] & ~commit_kill[rd_q[i]];
            rs1_rdy_n[i] = rs1_rdy_q[i] | woken(rs1_q[i], wake_valid, wake_rd, int_wake, alu_rd);
            rs2_rdy_n[i] = rs2_rdy_q[i] | woken(rs2_q[i], wake_valid, wake_rd, int_wake, alu_rd);
        end
        if (do_write) begin
            valid_n[wr_idx]   = 1'b1;
            rs1_rdy_n[wr_idx] = in_rs1_ready | woken(in_rs1, wake_valid, wake_rd, int_wake, alu_rd);
            rs2_rdy_n[wr_idx] = ~in_needs_rs2 | in_rs2_ready
                                | woken(in_rs2, wake_valid, wake_rd, int_wake, alu_rd);
        end

        count_n = '0;
        for (int i = 0; i < NENT; i++)
            count_n = count_n + (LNENT+1)'(valid_n[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            rs1_rdy_q     <= '0;
            rs2_rdy_q     <= '0;
            count         <= '0;
            alu_enable    <= 1'b0;
            alu_control   <= '0;
            alu_rd        <= '0;
            alu_makes_rd  <= 1'b0;
            alu_needs_rs2 <= 1'b0;
            alu_immed     <= '0;
            alu_pc        <= '0;
            rf_rs1        <= '0;
            rf_rs2        <= '0;
            for (int i = 0; i < NENT; i++) begin
                age_q[i] <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_n;
            rs1_rdy_q <= rs1_rdy_n;
            rs2_rdy_q <= rs2_rdy_n;
            count     <= count_n;
            if (do_write) begin
                rd_q[wr_idx]   <= in_rd;
                rs1_q[wr_idx]  <= in_rs1;
                rs2_q[wr_idx]  <= in_rs2;
                ctl_q[wr_idx]  <= in_control;
                mrd_q[wr_idx]  <= in_makes_rd;
                nrs2_q[wr_idx] <= in_needs_rs2;
                imm_q[wr_idx]  <= in_immed;
                pc_q[wr_idx]   <= in_pc;
                age_q[wr_idx]  <= '0;
                for (int j = 0; j < NENT; j++)
                    if (j != int'(wr_idx)) age_q[j][wr_idx] <= 1'b1;
            end
            alu_enable <= any_sel;
            if (any_sel) begin
                alu_control   <= ctl_q[sel_idx];
                alu_rd        <= rd_q[sel_idx];
                alu_makes_rd  <= mrd_q[sel_idx];
                alu_needs_rs2 <= nrs2_q[sel_idx];
                alu_immed     <= imm_q[sel_idx];
                alu_pc        <= pc_q[sel_idx];
                rf_rs1        <= rs1_q[sel_idx];
                rf_rs2        <= rs2_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - scoreboard bench for alu_issue_sched
module tb_alu_issue_sched;
    localparam int CNTRL_SIZE = 7;
    localparam int NCOMMIT    = 32;
    localparam int LNCOMMIT   = 5;
    localparam int VA_SZ      = 48;
    localparam int NENT       = 8;
    localparam int LNENT      = 3;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, in_makes_rd, in_needs_rs2, in_rs1_ready, in_rs2_ready;
    logic [CNTRL_SIZE-1:0] in_control, alu_control;
    logic [LNCOMMIT-1:0] in_rd, in_rs1, in_rs2, wake_rd, alu_rd, rf_rs1, rf_rs2;
    logic [31:0] in_immed, alu_immed;
    logic [VA_SZ-1:1] in_pc, alu_pc;
    logic wake_valid, alu_enable, alu_makes_rd, alu_needs_rs2;
    logic [NCOMMIT-1:0] commit_kill;
    logic [LNENT:0] count;

    alu_issue_sched #(.CNTRL_SIZE(CNTRL_SIZE), .NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT),
                      .VA_SZ(VA_SZ), .NENT(NENT), .LNENT(LNENT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_control(in_control), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
        .in_needs_rs2(in_needs_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready), .in_immed(in_immed),
        .in_pc(in_pc), .wake_valid(wake_valid), .wake_rd(wake_rd), .commit_kill(commit_kill),
        .alu_enable(alu_enable), .alu_control(alu_control), .alu_rd(alu_rd),
        .alu_makes_rd(alu_makes_rd), .alu_needs_rs2(alu_needs_rs2), .alu_immed(alu_immed),
        .alu_pc(alu_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    logic [2*LNCOMMIT+31:0] exp_q[$];
    int issue_cyc[$];

    // Scoreboard: every issue must match the next expected {rs1, rd, immed}
    always @(negedge clk) begin
        if (!reset && alu_enable) begin
            issue_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_issue got rd=%0d expected none", alu_rd);
            end else begin
                logic [2*LNCOMMIT+31:0] e;
                e = exp_q.pop_front();
                if ({rf_rs1, alu_rd, alu_immed} !== e)
                    $display("FAIL issue_fields got rs1=%0d rd=%0d imm=%h expected rs1=%0d rd=%0d imm=%h",
                             rf_rs1, alu_rd, alu_immed, e[41:37], e[36:32], e[31:0]);
                else
                    passed++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 0; in_control = '0; in_rd = '0; in_makes_rd = 0; in_needs_rs2 = 0;
        in_rs1 = '0; in_rs2 = '0; in_rs1_ready = 0; in_rs2_ready = 0;
        in_immed = '0; in_pc = '0; wake_valid = 0; wake_rd = '0; commit_kill = '0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [4:0] rs1, input logic r1, input logic expect_issue);
        in_valid = 1; in_rd = rd; in_rs1 = rs1; in_rs1_ready = r1;
        in_control = 7'(rd) + 7'd3; in_makes_rd = 1; in_needs_rs2 = 0;
        in_rs2 = 5'd31; in_rs2_ready = 0;
        in_immed = 32'h1000 + 32'(rd); in_pc = 47'(rd) << 2;
        if (expect_issue) exp_q.push_back({rs1, rd, 32'h1000 + 32'(rd)});
    endtask

    task automatic wait_issues(input int n, input int budget);
        int b = 0;
        while (issue_cyc.size() < n && b < budget) begin
            tick();
            b++;
        end
        total++;
        if (issue_cyc.size() !== n)
            $display("FAIL issue_count got %0d expected %0d", issue_cyc.size(), n);
        else
            passed++;
    endtask

    task automatic test_reset;
        idle();
        reset = 1;
        tick(); tick();
        total++;
        if ({count, in_ready, alu_enable, alu_makes_rd} !== {4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_ctrl got count=%0d rdy=%b en=%b mrd=%b expected 0 1 0 0",
                     count, in_ready, alu_enable, alu_makes_rd);
        else passed++;
        total++;
        if ({alu_rd, rf_rs1, rf_rs2, alu_immed, alu_control} !== '0)
            $display("FAIL reset_data got rd=%0d rs1=%0d imm=%h expected 0", alu_rd, rf_rs1, alu_immed);
        else passed++;
        reset = 0;
        tick();
    endtask

    task automatic test_basic;
        int c, peak;
        issue_cyc.delete();
        c = cyc;
        put(5'd1, 5'd0, 1, 1); tick();
        put(5'd2, 5'd0, 1, 1); tick();
        put(5'd3, 5'd0, 1, 1); tick();
        idle();
        peak = 0;
        for (int k = 0; k < 6; k++) begin
            if (int'(count) > peak) peak = int'(count);
            tick();
        end
        wait_issues(3, 4);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (issue_cyc.size() > k && issue_cyc[k] == c + 2 + k) passed++;
            else $display("FAIL basic_latency op%0d got cycle %0d expected %0d",
                          k, (issue_cyc.size() > k) ? issue_cyc[k] - c : -1, 2 + k);
        end
        total++;
        if (peak < 1 || peak > 2) $display("FAIL basic_peak got %0d expected 1..2", peak);
        else passed++;
        total++;
        if (count !== 4'd0) $display("FAIL basic_drain got count=%0d expected 0", count);
        else passed++;
    endtask

    task automatic test_full;
        int w;
        issue_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            put(5'(12 + k), 5'd20, 0, 0);
            tick();
        end
        idle();
        total++;
        if ({count, in_ready} !== {4'd8, 1'b0})
            $display("FAIL full_state got count=%0d rdy=%b expected 8 0", count, in_ready);
        else passed++;
        for (int k = 0; k < 8; k++) exp_q.push_back({5'd20, 5'(12 + k), 32'h1000 + 32'(12 + k)});
        w = cyc;
        wake_valid = 1; wake_rd = 5'd20;
        tick();
        idle();
        total++;
        if (in_ready !== 1'b0 || alu_enable !== 1'b0)
            $display("FAIL full_wait got rdy=%b en=%b expected 0 0", in_ready, alu_enable);
        else passed++;
        tick();
        total++;
        if (in_ready !== 1'b1 || alu_enable !== 1'b1)
            $display("FAIL full_first_issue got rdy=%b en=%b expected 1 1", in_ready, alu_enable);
        else passed++;
        wait_issues(8, 20);
        total++;
        if (issue_cyc.size() == 8 && issue_cyc[0] == w + 2 && issue_cyc[7] == w + 9) passed++;
        else $display("FAIL full_timing got first=%0d expected %0d", issue_cyc.size() ? issue_cyc[0] - w : -1, 2);
    endtask

    task automatic test_chain;
        int c;
        issue_cyc.delete();
        c = cyc;
        put(5'd5, 5'd0, 1, 1); tick();
        put(5'd6, 5'd5, 0, 1); tick();
        idle();
        wait_issues(2, 10);
        total++;
        if (issue_cyc.size() == 2 && issue_cyc[0] == c + 2 && issue_cyc[1] == issue_cyc[0] + 2) passed++;
        else $display("FAIL chain_gap got %0d expected 2",
                      (issue_cyc.size() == 2) ? issue_cyc[1] - issue_cyc[0] : -1);
    endtask

    task automatic test_kill;
        issue_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            put(5'(8 + k), 5'd21, 0, 0);
            tick();
        end
        idle();
        total++;
        if (count !== 4'd4) $display("FAIL kill_pre got count=%0d expected 4", count);
        else passed++;
        commit_kill = 32'(1) << 9;
        tick();
        commit_kill = '0;
        total++;
        if (count !== 4'd3) $display("FAIL kill_count got count=%0d expected 3", count);
        else passed++;
        exp_q.push_back({5'd21, 5'd8,  32'h1008});
        exp_q.push_back({5'd21, 5'd10, 32'h100a});
        exp_q.push_back({5'd21, 5'd11, 32'h100b});
        wake_valid = 1; wake_rd = 5'd21;
        tick();
        idle();
        wait_issues(3, 10);
        repeat (4) tick();
        total++;
        if (issue_cyc.size() !== 3 || count !== 4'd0)
            $display("FAIL kill_never got issues=%0d count=%0d expected 3 0", issue_cyc.size(), count);
        else passed++;
    endtask

    task automatic test_hazard;
        int c;
        issue_cyc.delete();
        c = cyc;
        put(5'd13, 5'd7, 0, 1);
        wake_valid = 1; wake_rd = 5'd7;
        tick();
        idle();
        wait_issues(1, 6);
        total++;
        if (issue_cyc.size() == 1 && issue_cyc[0] == c + 2) passed++;
        else $display("FAIL wake_on_write got %0d expected 2", issue_cyc.size() ? issue_cyc[0] - c : -1);
        issue_cyc.delete();
        repeat (2) tick();
        put(5'd14, 5'd0, 1, 0);
        commit_kill = 32'(1) << 14;
        total++;
        if (in_ready !== 1'b1) $display("FAIL kill_in_ready got %b expected 1", in_ready);
        else passed++;
        tick();
        idle();
        repeat (4) tick();
        total++;
        if (count !== 4'd0 || issue_cyc.size() !== 0)
            $display("FAIL kill_on_write got count=%0d issues=%0d expected 0 0", count, issue_cyc.size());
        else passed++;
    endtask

    task automatic test_reset_mid;
        issue_cyc.delete();
        for (int k = 0; k < 5; k++) begin
            put(5'(24 + k), 5'd22, 0, 0);
            tick();
        end
        idle();
        total++;
        if (count !== 4'd5) $display("FAIL mid_pre got count=%0d expected 5", count);
        else passed++;
        reset = 1;
        tick();
        reset = 0;
        total++;
        if ({count, alu_enable, in_ready} !== {4'd0, 1'b0, 1'b1})
            $display("FAIL mid_reset got count=%0d en=%b rdy=%b expected 0 0 1", count, alu_enable, in_ready);
        else passed++;
        wake_valid = 1; wake_rd = 5'd22;
        tick();
        idle();
        repeat (4) tick();
        total++;
        if (issue_cyc.size() !== 0) $display("FAIL mid_dropped got issues=%0d expected 0", issue_cyc.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_chain();
        test_kill();
        test_hazard();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
